johnson_phase_monitor: RTL and testbench

- Sits directly downstream of the 4-bit Johnson counter and consumes its q bus.
- Decodes each legal Johnson code into a one-hot phase and a binary phase index, and counts completed 8-state cycles.
- Checks the incoming sequence for illegal codes, out-of-order steps and stalls, so the counter can drive phase-sequenced logic safely.

---
 rtl/johnson_phase_monitor_if.sv | 27 ++
 rtl/johnson_phase_monitor.sv | 136 +++++++++++++
 tb/tb_johnson_phase_monitor.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/johnson_phase_monitor_if.sv
// Bus between a 4-bit Johnson counter (master) and its phase monitor (slave).
// No valid/ready handshake: q and resync are sampled on every rising clk edge, and all monitor outputs are registered.
interface johnson_phase_monitor_if #(
    parameter int CW = 8
);
    logic [3:0]    q;
    logic          resync;
    logic [7:0]    phase;
    logic [2:0]    phase_idx;
    logic          wrap;
    logic [CW-1:0] cycle_cnt;
    logic          locked;
    logic          stall;
    logic          err;
    logic [1:0]    err_code;
    logic [1:0]    dbg_state;

    modport master (
        output q, resync,
        input  phase, phase_idx, wrap, cycle_cnt, locked, stall, err, err_code, dbg_state
    );

    modport slave (
        input  q, resync,
        output phase, phase_idx, wrap, cycle_cnt, locked, stall, err, err_code, dbg_state
    );
endinterface

// File: rtl/johnson_phase_monitor.sv
// Decodes a 4-bit Johnson counter into phase/index, counts completed cycles,
// and flags illegal codes, out-of-order steps and stalls.
module johnson_phase_monitor #(
    parameter int CW       = 8,
    parameter int HOLD_MAX = 15
) (
    input  logic                    clk,
    input  logic                    clr,
    johnson_phase_monitor_if.slave  mon
);
    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    state_t        state_r;
    logic [3:0]    q_r;
    logic [7:0]    phase_r;
    logic [2:0]    idx_r;
    logic          wrap_r;
    logic [CW-1:0] cnt_r;
    logic          locked_r;
    logic          stall_r;
    logic          err_r;
    logic [1:0]    err_code_r;
    logic [7:0]    hold_cnt;

    logic [2:0]    idx_nxt;
    logic [7:0]    hold_nxt;

    function automatic logic [3:0] jcode(input logic [2:0] idx);
        case (idx)
            3'd0:    jcode = 4'b0000;
            3'd1:    jcode = 4'b0001;
            3'd2:    jcode = 4'b0011;
            3'd3:    jcode = 4'b0111;
            3'd4:    jcode = 4'b1111;
            3'd5:    jcode = 4'b1110;
            3'd6:    jcode = 4'b1100;
            default: jcode = 4'b1000;
        endcase
    endfunction

    function automatic logic is_legal(input logic [3:0] code);
        case (code)
            4'b0000, 4'b0001, 4'b0011, 4'b0111,
            4'b1111, 4'b1110, 4'b1100, 4'b1000: is_legal = 1'b1;
            default:                            is_legal = 1'b0;
        endcase
    endfunction

    // hold_nxt saturates so a long stall never wraps back below HOLD_MAX
    always_comb begin
        idx_nxt  = idx_r + 3'd1;
        hold_nxt = hold_cnt;
        if (hold_cnt != HOLD_LIM) begin
            hold_nxt = hold_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r    <= SYNC;
            q_r        <= 4'b0000;
            phase_r    <= 8'd0;
            idx_r      <= 3'd0;
            wrap_r     <= 1'b0;
            cnt_r      <= '0;
            locked_r   <= 1'b0;
            stall_r    <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= 2'b00;
            hold_cnt   <= 8'd0;
        end else begin
            q_r    <= mon.q;
            wrap_r <= 1'b0;
            case (state_r)
                SYNC: begin
                    if (q_r == 4'b0000) begin
                        state_r  <= TRACK;
                        idx_r    <= 3'd0;
                        phase_r  <= 8'b0000_0001;
                        locked_r <= 1'b1;
                        hold_cnt <= 8'd0;
                        stall_r  <= 1'b0;
                    end
                end
                TRACK: begin
                    if (q_r == jcode(idx_nxt)) begin
                        idx_r    <= idx_nxt;
                        phase_r  <= 8'b0000_0001 << idx_nxt;
                        hold_cnt <= 8'd0;
                        stall_r  <= 1'b0;
                        if (idx_r == 3'd7) begin
                            wrap_r <= 1'b1;
                            cnt_r  <= cnt_r + CW'(1);
                        end
                    end else if (q_r == jcode(idx_r)) begin
                        hold_cnt <= hold_nxt;
                        stall_r  <= (hold_nxt == HOLD_LIM);
                    end else begin
                        state_r    <= FAULT;
                        err_r      <= 1'b1;
                        err_code_r <= is_legal(q_r) ? 2'b10 : 2'b01;
                        locked_r   <= 1'b0;
                        phase_r    <= 8'd0;
                        stall_r    <= 1'b0;
                        hold_cnt   <= 8'd0;
                    end
                end
                FAULT: begin
                    // resync only matters here; a fault detected in TRACK always wins
                    if (mon.resync) begin
                        state_r    <= SYNC;
                        err_r      <= 1'b0;
                        err_code_r <= 2'b00;
                    end
                end
                default: state_r <= SYNC;
            endcase
        end
    end

    assign mon.phase     = phase_r;
    assign mon.phase_idx = idx_r;
    assign mon.wrap      = wrap_r;
    assign mon.cycle_cnt = cnt_r;
    assign mon.locked    = locked_r;
    assign mon.stall     = stall_r;
    assign mon.err       = err_r;
    assign mon.err_code  = err_code_r;
    assign mon.dbg_state = state_r;
endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Directed bench for johnson_phase_monitor: two instances (CW=8 and CW=2) share
// the clock, reset and q stimulus; outputs are sampled on the falling edge.
module tb_johnson_phase_monitor;
    localparam int W = 22;
    localparam logic [1:0] S_SYNC  = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    logic clk;
    logic clr;
    int   n_chk;
    int   n_bad;
    logic [W-1:0] exp_q[$];

    johnson_phase_monitor_if #(.CW(8)) m8 ();
    johnson_phase_monitor_if #(.CW(2)) m2 ();

    johnson_phase_monitor #(.CW(8), .HOLD_MAX(15)) u8 (.clk(clk), .clr(clr), .mon(m8.slave));
    johnson_phase_monitor #(.CW(2), .HOLD_MAX(15)) u2 (.clk(clk), .clr(clr), .mon(m2.slave));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic drive(input logic [3:0] v);
        m8.q = v;
        m2.q = v;
    endtask

    task automatic set_resync(input logic v);
        m8.resync = v;
        m2.resync = v;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [3:0] jcode(input int i);
        case (i % 8)
            0:       jcode = 4'b0000;
            1:       jcode = 4'b0001;
            2:       jcode = 4'b0011;
            3:       jcode = 4'b0111;
            4:       jcode = 4'b1111;
            5:       jcode = 4'b1110;
            6:       jcode = 4'b1100;
            default: jcode = 4'b1000;
        endcase
    endfunction

    // scoreboard
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_phase"}, 32'(m8.phase), 32'h0);
        chk({tag, "_idx"},   32'(m8.phase_idx), 32'h0);
        chk({tag, "_wrap"},  32'(m8.wrap), 32'h0);
        chk({tag, "_cnt8"},  32'(m8.cycle_cnt), 32'h0);
        chk({tag, "_cnt2"},  32'(m2.cycle_cnt), 32'h0);
        chk({tag, "_lock"},  32'(m8.locked), 32'h0);
        chk({tag, "_stall"}, 32'(m8.stall), 32'h0);
        chk({tag, "_err"},   32'(m8.err), 32'h0);
        chk({tag, "_ecode"}, 32'(m8.err_code), 32'h0);
        chk({tag, "_state"}, 32'(m8.dbg_state), 32'(S_SYNC));
    endtask

    initial begin
        logic [W-1:0] e;
        logic [7:0]   e_cnt8;
        logic [1:0]   e_cnt2;
        logic         e_wrap;
        logic [2:0]   e_idx;
        logic [7:0]   e_phase;
        n_chk = 0;
        n_bad = 0;
        clr = 1'b0;
        drive(4'b0000);
        set_resync(1'b0);

        // reset values, then release with q=0000 so the first compare locks
        wait_cyc(3);
        chk_cleared("rst");
        clr = 1'b1;
        wait_cyc(2);
        chk("lock_first", 32'(m8.locked), 32'h1);
        chk("lock_phase", 32'(m8.phase), 32'h01);
        chk("lock_state", 32'(m8.dbg_state), 32'(S_TRACK));

        // free-running counter for 40 steps; outputs lag the driven code by 2 cycles
        for (int i = 1; i <= 42; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                e = exp_q.pop_front();
                {e_cnt8, e_cnt2, e_wrap, e_idx, e_phase} = e;
                chk("run_phase", 32'(m8.phase), 32'(e_phase));
                chk("run_idx",   32'(m8.phase_idx), 32'(e_idx));
                chk("run_wrap",  32'(m8.wrap), 32'(e_wrap));
                chk("run_cnt8",  32'(m8.cycle_cnt), 32'(e_cnt8));
                chk("run_cnt2",  32'(m2.cycle_cnt), 32'(e_cnt2));
                chk("run_lock",  32'(m8.locked), 32'h1);
            end
            if (i <= 40) begin
                drive(jcode(i));
                e_cnt8  = 8'(i / 8);
                e_cnt2  = 2'((i / 8) % 4);
                e_wrap  = (i % 8 == 0);
                e_idx   = 3'(i % 8);
                e_phase = 8'(1 << (i % 8));
                exp_q.push_back({e_cnt8, e_cnt2, e_wrap, e_idx, e_phase});
            end
        end

        // stall: hold 0111 for 20 cycles, then advance to 1111
        @(negedge clk); drive(4'b0001);
        @(negedge clk); drive(4'b0011);
        @(negedge clk); drive(4'b0111);
        wait_cyc(2);
        chk("hold_idx",   32'(m8.phase_idx), 32'd3);
        chk("hold_phase", 32'(m8.phase), 32'h08);
        chk("hold_stall0", 32'(m8.stall), 32'h0);
        wait_cyc(14);
        chk("stall_early", 32'(m8.stall), 32'h0);
        wait_cyc(1);
        chk("stall_set", 32'(m8.stall), 32'h1);
        chk("stall_lock", 32'(m8.locked), 32'h1);
        chk("stall_err",  32'(m8.err), 32'h0);
        wait_cyc(3);
        chk("stall_keep", 32'(m8.stall), 32'h1);
        drive(4'b1111);
        wait_cyc(2);
        chk("stall_clr", 32'(m8.stall), 32'h0);
        chk("adv_idx",   32'(m8.phase_idx), 32'd4);
        chk("adv_phase", 32'(m8.phase), 32'h10);

        // illegal code at idx 2, with resync raised in the detecting cycle
        for (int k = 5; k <= 10; k++) begin
            @(negedge clk);
            drive(jcode(k));
        end
        wait_cyc(2);
        chk("pre_ill_idx", 32'(m8.phase_idx), 32'd2);
        chk("pre_ill_cnt8", 32'(m8.cycle_cnt), 32'd6);
        drive(4'b0101);
        @(negedge clk); set_resync(1'b1);
        @(negedge clk);
        chk("ill_err",   32'(m8.err), 32'h1);
        chk("ill_code",  32'(m8.err_code), 32'h1);
        chk("ill_lock",  32'(m8.locked), 32'h0);
        chk("ill_phase", 32'(m8.phase), 32'h0);
        chk("ill_idx",   32'(m8.phase_idx), 32'd2);
        chk("ill_state", 32'(m8.dbg_state), 32'(S_FAULT));
        set_resync(1'b0);
        @(negedge clk);
        chk("ill_hold_err",   32'(m8.err), 32'h1);
        chk("ill_hold_state", 32'(m8.dbg_state), 32'(S_FAULT));
        set_resync(1'b1);
        @(negedge clk);
        set_resync(1'b0);
        chk("rs_err",   32'(m8.err), 32'h0);
        chk("rs_code",  32'(m8.err_code), 32'h0);
        chk("rs_state", 32'(m8.dbg_state), 32'(S_SYNC));
        chk("rs_cnt8",  32'(m8.cycle_cnt), 32'd6);
        drive(4'b0000);
        @(negedge clk);
        chk("relock_early", 32'(m8.locked), 32'h0);
        @(negedge clk);
        chk("relock",       32'(m8.locked), 32'h1);
        chk("relock_phase", 32'(m8.phase), 32'h01);
        chk("relock_cnt8",  32'(m8.cycle_cnt), 32'd6);
        chk("relock_cnt2",  32'(m2.cycle_cnt), 32'd2);

        // legal but out-of-order code at idx 5
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            drive(jcode(k));
        end
        wait_cyc(2);
        chk("pre_ooo_idx",   32'(m8.phase_idx), 32'd5);
        chk("pre_ooo_phase", 32'(m8.phase), 32'h20);
        drive(4'b0011);
        wait_cyc(2);
        chk("ooo_err",  32'(m8.err), 32'h1);
        chk("ooo_code", 32'(m8.err_code), 32'h2);
        chk("ooo_idx",  32'(m8.phase_idx), 32'd5);
        set_resync(1'b1);
        @(negedge clk);
        set_resync(1'b0);
        drive(4'b0001);
        chk("ooo_rs_state", 32'(m8.dbg_state), 32'(S_SYNC));
        wait_cyc(2);
        chk("sync_state", 32'(m8.dbg_state), 32'(S_SYNC));
        chk("sync_err",   32'(m8.err), 32'h0);
        chk("sync_code",  32'(m8.err_code), 32'h0);
        chk("sync_lock",  32'(m8.locked), 32'h0);

        // asynchronous reset while tracking at idx 6
        @(negedge clk); drive(4'b0000);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            drive(jcode(k));
        end
        wait_cyc(2);
        chk("pre_rst_idx",  32'(m8.phase_idx), 32'd6);
        chk("pre_rst_phase", 32'(m8.phase), 32'h40);
        chk("pre_rst_cnt8", 32'(m8.cycle_cnt), 32'd6);
        #2;
        clr = 1'b0;
        #1;
        chk_cleared("arst");
        drive(4'b0000);
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk("post_rst_state", 32'(m8.dbg_state), 32'(S_SYNC));
        @(negedge clk);
        chk("post_rst_lock", 32'(m8.locked), 32'h1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
